// File: rtl/ts_alloc_ctrl.sv
// Timeslot allocation controller: double-buffered allocation bitmap with a host shadow bank,
// superframe-aligned commit, 1-cycle parser lookup and saturating hit/miss statistics.
module ts_alloc_ctrl #(
    parameter int TS_AW  = 10,
    parameter int TS_NUM = 1024,
    parameter int CNT_W  = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             byte_rd,
    input  logic [TS_AW-1:0] timeslot,
    output logic             ts_vld,
    input  logic             cfg_wr_en,
    input  logic [TS_AW-1:0] cfg_addr,
    input  logic             cfg_wr_data,
    input  logic             cfg_clear,
    input  logic             cfg_commit,
    output logic             cfg_ready,
    output logic             commit_pending,
    output logic             commit_done,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR,
        ST_PEND,
        ST_COPY
    } state_t;

    state_t           state_q;
    logic [TS_AW-1:0] waddr_q;
    logic             bank_sel_q;
    logic             ready_q;
    logic             pend_q;
    logic             done_q;
    logic             vld_q;
    logic             vld_d;
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] hit_d;
    logic [CNT_W-1:0] miss_q;
    logic [CNT_W-1:0] miss_d;

    logic [TS_NUM-1:0] bank0_q;
    logic [TS_NUM-1:0] bank1_q;

    logic             wr_last;
    logic             swap;
    logic             rd_bank;
    logic             rd_bit;
    logic             lookup_en;
    logic             copy_bit;
    logic             init_we;
    logic             sh_we;
    logic             we0;
    logic             we1;
    logic [TS_AW-1:0] wr_addr;
    logic             wr_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign wr_last   = (waddr_q == TS_AW'(TS_NUM - 1));
    // The swapping lookup must already see the incoming bank, so select ahead of the toggle.
    assign swap      = (state_q == ST_PEND) && byte_rd && (timeslot == '0);
    assign rd_bank   = bank_sel_q ^ swap;
    assign rd_bit    = rd_bank ? bank1_q[timeslot] : bank0_q[timeslot];
    assign lookup_en = byte_rd && (state_q != ST_INIT);
    assign copy_bit  = bank_sel_q ? bank1_q[waddr_q] : bank0_q[waddr_q];

    always_comb begin
        sh_we   = 1'b0;
        wr_addr = waddr_q;
        wr_data = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready_q && cfg_wr_en && !cfg_clear) begin
                    sh_we   = 1'b1;
                    wr_addr = cfg_addr;
                    wr_data = cfg_wr_data;
                end
            end
            ST_CLEAR: sh_we = 1'b1;
            ST_COPY: begin
                sh_we   = 1'b1;
                wr_data = copy_bit;
            end
            default: ;
        endcase
    end

    // The shadow is whichever bank bank_sel does not point at.
    assign init_we = (state_q == ST_INIT);
    assign we0     = init_we | (sh_we & bank_sel_q);
    assign we1     = init_we | (sh_we & ~bank_sel_q);

    always_ff @(posedge sys_clk) begin
        if (we0) bank0_q[wr_addr] <= wr_data;
        if (we1) bank1_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            waddr_q    <= '0;
            bank_sel_q <= 1'b0;
            ready_q    <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    waddr_q <= waddr_q + TS_AW'(1);
                    if (wr_last) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cfg_clear) begin
                        state_q <= ST_CLEAR;
                        waddr_q <= '0;
                        ready_q <= 1'b0;
                    end else if (cfg_commit) begin
                        state_q <= ST_PEND;
                        ready_q <= 1'b0;
                        pend_q  <= 1'b1;
                    end
                end
                ST_CLEAR, ST_COPY: begin
                    waddr_q <= waddr_q + TS_AW'(1);
                    if (wr_last) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (swap) begin
                        bank_sel_q <= ~bank_sel_q;
                        state_q    <= ST_COPY;
                        waddr_q    <= '0;
                        pend_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        vld_d  = vld_q;
        hit_d  = hit_q;
        miss_d = miss_q;
        if (byte_rd) vld_d = lookup_en & rd_bit;
        if (cnt_clr) begin
            hit_d  = '0;
            miss_d = '0;
        end else if (lookup_en) begin
            if (rd_bit) hit_d = sat_inc(hit_q);
            else        miss_d = sat_inc(miss_q);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            vld_q  <= vld_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign ts_vld         = vld_q;
    assign cfg_ready      = ready_q;
    assign commit_pending = pend_q;
    assign commit_done    = done_q;
    assign hit_cnt        = hit_q;
    assign miss_cnt       = miss_q;

endmodule

// File: tb/tb_ts_alloc_ctrl.sv
// Scoreboard bench for ts_alloc_ctrl: a phase/countdown reference model over plain bit arrays
// predicts every cycle's outputs; a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_ts_alloc_ctrl;
    localparam int TS_AW  = 10;
    localparam int TS_NUM = 1024;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int PH_INIT = 0, PH_IDLE = 1, PH_CLEAR = 2, PH_PEND = 3, PH_COPY = 4;

    logic             sys_clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             byte_rd = 1'b0;
    logic [TS_AW-1:0] timeslot = '0;
    logic             ts_vld;
    logic             cfg_wr_en = 1'b0;
    logic [TS_AW-1:0] cfg_addr = '0;
    logic             cfg_wr_data = 1'b0;
    logic             cfg_clear = 1'b0;
    logic             cfg_commit = 1'b0;
    logic             cfg_ready;
    logic             commit_pending;
    logic             commit_done;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    ts_alloc_ctrl #(.TS_AW(TS_AW), .TS_NUM(TS_NUM), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .byte_rd(byte_rd), .timeslot(timeslot),
        .ts_vld(ts_vld), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_clear(cfg_clear), .cfg_commit(cfg_commit),
        .cfg_ready(cfg_ready), .commit_pending(commit_pending), .commit_done(commit_done),
        .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit vld;
        bit ready;
        bit pend;
        bit done;
        int hit;
        int miss;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state
    int m_phase;
    int m_left;
    bit m_act[TS_NUM];
    bit m_shd[TS_NUM];
    bit m_vld;
    int m_hit;
    int m_miss;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_INIT;
        m_left  = TS_NUM;
        foreach (m_act[i]) m_act[i] = 1'b0;
        foreach (m_shd[i]) m_shd[i] = 1'b0;
        m_vld  = 1'b0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    // Called at a falling edge: drive one cycle, predict its outcome, advance to the next falling edge.
    task automatic drive(input bit rd, input int ts, input bit wr, input int a, input bit d,
                         input bit clr, input bit cm, input bit cc);
        exp_t e;
        bit   swap, counted, val, done;
        bit   tmp[TS_NUM];
        byte_rd     = rd;
        timeslot    = ts[TS_AW-1:0];
        cfg_wr_en   = wr;
        cfg_addr    = a[TS_AW-1:0];
        cfg_wr_data = d;
        cfg_clear   = clr;
        cfg_commit  = cm;
        cnt_clr     = cc;

        swap    = rd && (m_phase == PH_PEND) && (ts == 0);
        counted = rd && (m_phase != PH_INIT);
        val     = 1'b0;
        if (counted) val = swap ? m_shd[ts] : m_act[ts];
        if (rd) m_vld = val;
        if (cc) begin
            m_hit  = 0;
            m_miss = 0;
        end else if (counted) begin
            if (val) m_hit  = (m_hit  < CMAX) ? m_hit + 1  : CMAX;
            else     m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
        end
        done = 1'b0;
        case (m_phase)
            PH_INIT: begin
                m_left--;
                if (m_left == 0) m_phase = PH_IDLE;
            end
            PH_IDLE: begin
                if (clr) begin
                    m_phase = PH_CLEAR;
                    m_left  = TS_NUM;
                    foreach (m_shd[i]) m_shd[i] = 1'b0;
                end else begin
                    if (wr) m_shd[a] = d;
                    if (cm) m_phase = PH_PEND;
                end
            end
            PH_CLEAR: begin
                m_left--;
                if (m_left == 0) m_phase = PH_IDLE;
            end
            PH_PEND: begin
                if (swap) begin
                    tmp     = m_act;
                    m_act   = m_shd;
                    m_shd   = tmp;
                    m_phase = PH_COPY;
                    m_left  = TS_NUM;
                    done    = 1'b1;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = PH_IDLE;
                    m_shd   = m_act;
                end
            end
        endcase
        e.vld   = m_vld;
        e.ready = (m_phase == PH_IDLE);
        e.pend  = (m_phase == PH_PEND);
        e.done  = done;
        e.hit   = m_hit;
        e.miss  = m_miss;
        sbq.push_back(e);
        @(negedge sys_clk);
    endtask

    task automatic lookup(input int ts);
        drive(1'b1, ts, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cfgw(input int a, input bit d, input bit cm);
        drive(1'b0, 0, 1'b1, a, d, 1'b0, cm, 1'b0);
    endtask

    task automatic commit_only();
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Random traffic; config strobes only outside IDLE, where they must be ignored.
    task automatic rnd_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bit rd, wr, d, cl, cm, cc;
            int ts, a;
            rd = ($urandom_range(0, 1) == 1);
            ts = (m_phase == PH_PEND) ? int'($urandom_range(1, TS_NUM - 1))
                                      : int'($urandom_range(0, TS_NUM - 1));
            cc = ($urandom_range(0, 63) == 0);
            wr = 1'b0; cl = 1'b0; cm = 1'b0; d = 1'b0; a = 0;
            if (m_phase != PH_IDLE) begin
                wr = ($urandom_range(0, 7) == 0);
                a  = int'($urandom_range(0, TS_NUM - 1));
                d  = 1'b1;
                cl = ($urandom_range(0, 31) == 0);
                cm = ($urandom_range(0, 31) == 0);
            end
            drive(rd, ts, wr, a, d, cl, cm, cc);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with reset released and the model in INIT.
    task automatic do_reset();
        rst_n = 1'b0;
        byte_rd = 1'b0; cfg_wr_en = 1'b0; cfg_clear = 1'b0; cfg_commit = 1'b0; cnt_clr = 1'b0;
        #1;
        check("rst_ts_vld", int'(ts_vld), 0);
        check("rst_cfg_ready", int'(cfg_ready), 0);
        check("rst_commit_pending", int'(commit_pending), 0);
        check("rst_commit_done", int'(commit_done), 0);
        check("rst_hit_cnt", int'(hit_cnt), 0);
        check("rst_miss_cnt", int'(miss_cnt), 0);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_ts_vld", int'(ts_vld), int'(e.vld));
                check("sb_cfg_ready", int'(cfg_ready), int'(e.ready));
                check("sb_commit_pending", int'(commit_pending), int'(e.pend));
                check("sb_commit_done", int'(commit_done), int'(e.done));
                check("sb_hit_cnt", int'(hit_cnt), e.hit);
                check("sb_miss_cnt", int'(miss_cnt), e.miss);
            end
        end
    end

    initial begin : stimulus
        @(negedge sys_clk);
        do_reset();

        // INIT: lookup ignored, ready after exactly TS_NUM cycles
        lookup(5);
        check("init_lookup_vld", int'(ts_vld), 0);
        check("init_lookup_hit", int'(hit_cnt) + int'(miss_cnt), 0);
        rnd_ticks(TS_NUM - 2);
        check("init_not_ready_yet", int'(cfg_ready), 0);
        rnd_ticks(1);
        check("init_ready_at_1024", int'(cfg_ready), 1);

        // Commit waits for slot 0
        cfgw(3, 1'b1, 1'b0);
        cfgw(TS_NUM - 1, 1'b1, 1'b0);
        commit_only();
        check("pend_set", int'(commit_pending), 1);
        lookup(3);
        check("pre_swap_slot3", int'(ts_vld), 0);
        rnd_ticks(20);
        lookup(0);
        check("swap_done_pulse", int'(commit_done), 1);
        lookup(3);
        check("post_swap_slot3", int'(ts_vld), 1);
        lookup(TS_NUM - 1);
        check("post_swap_slot1023", int'(ts_vld), 1);
        lookup(4);
        check("post_swap_slot4", int'(ts_vld), 0);
        rnd_ticks(TS_NUM + 8);

        // Copy preserved prior allocation; write and commit in the same cycle
        cfgw(4, 1'b1, 1'b1);
        rnd_ticks(5);
        lookup(0);
        lookup(3);
        check("copy_kept_slot3", int'(ts_vld), 1);
        lookup(TS_NUM - 1);
        check("copy_kept_slot1023", int'(ts_vld), 1);
        lookup(4);
        check("new_slot4", int'(ts_vld), 1);
        rnd_ticks(TS_NUM + 8);

        // Clear beats commit and discards a coincident write
        drive(1'b0, 0, 1'b1, 9, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_no_pending", int'(commit_pending), 0);
        check("clr_not_ready", int'(cfg_ready), 0);
        rnd_ticks(TS_NUM + 4);
        commit_only();
        lookup(0);
        for (int s = 0; s < TS_NUM; s++) lookup(s);
        rnd_ticks(16);

        // Writes during PENDING and COPY are ignored
        commit_only();
        cfgw(7, 1'b1, 1'b0);
        rnd_ticks(10);
        lookup(0);
        cfgw(7, 1'b1, 1'b0);
        rnd_ticks(TS_NUM + 4);
        commit_only();
        lookup(0);
        lookup(7);
        check("ignored_slot7", int'(ts_vld), 0);
        rnd_ticks(TS_NUM + 4);

        // Randomized allocation rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++)
                cfgw(int'($urandom_range(0, TS_NUM - 1)), 1'($urandom_range(0, 1)), 1'b0);
            commit_only();
            rnd_ticks(int'($urandom_range(1, 30)));
            lookup(0);
            rnd_ticks(TS_NUM + 4);
        end

        // Counter saturation and clear priority
        cfgw(9, 1'b1, 1'b1);
        lookup(0);
        rnd_ticks(TS_NUM + 4);
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < CMAX - 1; k++) lookup(9);
        check("hit_below_sat", int'(hit_cnt), CMAX - 1);
        for (int k = 0; k < 3; k++) lookup(9);
        check("hit_saturated", int'(hit_cnt), CMAX);
        drive(1'b1, 9, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_beats_hit", int'(hit_cnt), 0);

        // Reset while PENDING
        commit_only();
        check("pend_before_rst", int'(commit_pending), 1);
        do_reset();
        lookup(9);
        check("reinit_lookup", int'(ts_vld), 0);
        rnd_ticks(TS_NUM + 4);
        lookup(9);
        check("rezeroed_slot9", int'(ts_vld), 0);

        repeat (2) @(posedge sys_clk);
        #2;
        check("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ts_alloc_ctrl.md
Name: ts_alloc_ctrl

Overview:
- Timeslot allocation controller for the downlink frame parser.
- Holds a double-buffered 1024-entry bitmap of the timeslots assigned to this terminal. Answers each parser lookup (byte_rd + 10-bit timeslot) with ts_vld one cycle later.
- Host edits a shadow bank through a config port. A commit swaps the shadow bank in at the next superframe boundary, so allocation changes never land mid-superframe.

Parameters:
- TS_AW, 10, timeslot address width ({slot[4:0], ldpc[4:0]}).
- TS_NUM, 1024, table depth; must equal 2**TS_AW.
- CNT_W, 16, width of the hit/miss statistics counters.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- byte_rd  in  1  lookup strobe from frame parser, single-cycle pulse.
- timeslot  in  TS_AW  slot index, sampled when byte_rd=1.
- ts_vld  out  1  1 = looked-up slot allocated; held until next lookup.
- cfg_wr_en  in  1  write one shadow-bank entry; accepted only when cfg_ready=1.
- cfg_addr  in  TS_AW  shadow entry index.
- cfg_wr_data  in  1  1 = allocate, 0 = release.
- cfg_clear  in  1  pulse: zero the entire shadow bank.
- cfg_commit  in  1  pulse: request a shadow/active swap at the next boundary.
- cfg_ready  out  1  1 = shadow bank writable and commit/clear accepted.
- commit_pending  out  1  commit armed, waiting for boundary.
- commit_done  out  1  one-cycle pulse, cycle after the swap.
- cnt_clr  in  1  synchronous clear of hit_cnt/miss_cnt.
- hit_cnt  out  CNT_W  lookups returning 1, saturating.
- miss_cnt  out  CNT_W  lookups returning 0, saturating.

Behaviour:
- Storage:
  - Two 1024x1 banks, bank0 and bank1. Register bank_sel selects the active bank; the other is the shadow.
  - Active bank has two read ports: lookup and copy. Shadow bank has one write port.
- Reset (async):
  - Outputs: ts_vld=0, cfg_ready=0, commit_pending=0, commit_done=0, hit_cnt=0, miss_cnt=0.
  - Internal: bank_sel=0, state=INIT, walk counter waddr=0.
  - Bank contents are not reset directly; INIT zeroes them.
- State machine (state, waddr[TS_AW-1:0]):
  - INIT: each cycle writes 0 to bank0[waddr] and bank1[waddr], waddr++. At waddr=TS_NUM-1 go to IDLE. Duration 1024 cycles. Lookups during INIT return ts_vld=0 and do not count.
  - IDLE: cfg_ready=1.
    - cfg_wr_en writes the shadow entry.
    - cfg_clear -> CLEAR, waddr=0. cfg_clear beats cfg_commit in the same cycle; the commit is dropped.
    - cfg_commit (no clear) -> PENDING.
    - cfg_wr_en with cfg_commit in the same cycle: the write lands, then PENDING.
    - cfg_wr_en with cfg_clear in the same cycle: the write is discarded.
  - CLEAR: writes 0 to shadow[waddr], waddr++; after 1024 cycles -> IDLE. cfg_ready=0.
  - PENDING: cfg_ready=0, commit_pending=1. Swap happens on the first byte_rd with timeslot==0.
    - bank_sel toggles in that cycle, and that lookup already reads the new active bank.
    - Next cycle: commit_done=1, state COPY, waddr=0.
  - COPY: shadow[waddr] <= active[waddr], waddr++. After 1024 cycles -> IDLE, so the shadow again mirrors the active bank. cfg_ready=0.
- Config accept rule: cfg_wr_en/cfg_clear/cfg_commit asserted with cfg_ready=0 are ignored, no queueing.
- Lookup:
  - byte_rd in cycle N -> ts_vld valid in cycle N+1 = active[timeslot]. Fixed 1-cycle latency.
  - ts_vld holds until the next byte_rd.
  - Lookups are served in every state except INIT, including PENDING/COPY/CLEAR; they always use the active bank.
  - Back-to-back byte_rd is legal; each cycle returns a new result.
- Counters:
  - Each counted lookup increments hit_cnt or miss_cnt in cycle N+1.
  - Saturate at 2**CNT_W-1.
  - cnt_clr has priority over increment in the same cycle.
- Wrap: waddr is TS_AW bits wide and wraps naturally. Terminal detection uses waddr==TS_NUM-1.
- Reset mid-operation (any state): async return to INIT. Banks are re-zeroed and any pending commit is lost.

Test Plan:
1. Release reset, count cycles -> cfg_ready rises 1024 cycles after reset deassertion. Lookup at slot 5 during INIT -> ts_vld=0, counters stay 0.
2. Write slots 3, 1023 =1, commit, then byte_rd on slot 3 -> ts_vld=0 (not yet swapped). Then byte_rd timeslot=0 -> commit_done next cycle. Then byte_rd slot 3 -> ts_vld=1 one cycle later; slot 1023 -> 1; slot 4 -> 0.
3. After scenario 2 COPY completes, write slot 4=1 and commit, swap at slot 0 -> slots 3, 1023, 4 all read 1. This proves the copy preserved the prior allocation.
4. cfg_clear and cfg_commit in the same cycle -> commit_pending stays 0 and cfg_ready=0 for 1024 cycles. After a later commit + swap, every slot reads 0.
5. Config writes to slot 7 during PENDING and COPY -> ignored; slot 7 reads 0 after a subsequent commit/swap. Lookups during COPY return the active-bank value with 1-cycle latency.
6. Force hit_cnt to 0xFFFE, apply 3 hits -> saturates at 0xFFFF. cnt_clr coincident with a hit -> 0. Assert rst_n low while PENDING -> commit_pending=0 immediately, INIT restarts.
